// File: rtl/if_pkg.sv
// -----------------------------------------------------------------------------
// if_pkg
// Shared types and constants for the instruction-fetch front end.
//   fetch_state_e : fetch FSM states (IDLE, FETCH, DRAIN)
//   NOP_INSTR     : instruction presented on inst_data while the queue is empty
//   PC_STEP       : byte increment between sequential fetches
// -----------------------------------------------------------------------------
package if_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int unsigned PC_STEP   = 4;

endpackage

// File: rtl/if_sync_fifo.sv
// -----------------------------------------------------------------------------
// if_sync_fifo
// Single-clock FIFO with registered storage and a synchronous flush.
// The head entry is read straight from storage, so data pushed on one edge is
// visible at o_head from the following cycle.
// Ports:
//   clk         : clock, rising edge
//   rst         : synchronous active-low reset
//   i_clear     : drop all entries (wins over a same-cycle push/pop)
//   i_push      : write i_push_data (ignored when full)
//   i_push_data : entry to write
//   i_pop       : discard head entry (ignored when empty)
//   o_head      : oldest entry
//   o_full      : DEPTH entries held
//   o_empty     : no entries held
//   o_count     : number of entries held
// -----------------------------------------------------------------------------
module if_sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_clear,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_push_data,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_head,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == (AW + 1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

    assign w_push = i_push & ~o_full;
    assign w_pop  = i_pop & ~o_empty;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

endmodule

// File: rtl/if_prefetch_unit.sv
// -----------------------------------------------------------------------------
// if_prefetch_unit
// Instruction-fetch front end: issues sequential word fetches, tags each
// outstanding request with its PC, and buffers {instruction, pc} pairs in a
// DEPTH-entry queue for decode. A redirect flushes the queue and restarts at
// the new PC; responses to requests issued before the redirect are dropped.
// Ports:
//   clk, rst          : clock and synchronous active-low reset
//   imem_req_*        : fetch request channel (valid/ready, word address)
//   imem_rsp_*        : in-order fetch responses, no backpressure
//   redirect_valid/pc : flush and restart fetch at redirect_pc & ~3
//   inst_*            : queue head to decode (valid/ready, data, pc)
// Optional build macro IF_PERF_CNT_EN adds saturating counters:
//   stall_cycles      : cycles with inst_ready=1 and inst_valid=0
//   flush_count       : cycles with redirect_valid=1
// -----------------------------------------------------------------------------
module if_prefetch_unit
    import if_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst_data,
    output logic [XLEN-1:0] inst_pc
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]     stall_cycles,
    output logic [31:0]     flush_count
`endif
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned QW = 32 + XLEN;

    fetch_state_e    r_state;
    fetch_state_e    w_state_next;
    logic [XLEN-1:0] r_fetch_pc;
    logic [CW-1:0]   r_drop_cnt;

    logic            w_req_fire;
    logic            w_rsp_keep;
    logic            w_inst_pop;
    logic [CW-1:0]   w_q_count;
    logic [CW-1:0]   w_inflight;
    logic [CW-1:0]   w_drop_redirect;
    logic [CW:0]     w_credit_used;
    logic            w_q_empty;
    logic            w_q_full;
    logic            w_tag_empty;
    logic            w_tag_full;
    logic [QW-1:0]   w_q_head;
    logic [XLEN-1:0] w_tag_head;

    assign w_req_fire = imem_req_valid & imem_req_ready;
    assign w_inst_pop = inst_valid & inst_ready;

    // Responses are only kept in FETCH; a response in a redirect cycle belongs
    // to the old stream and is discarded.
    assign w_rsp_keep = imem_rsp_valid & (r_state == FETCH) & ~redirect_valid & ~w_tag_empty;

    // Queue slots plus outstanding requests form the credit pool, so a
    // response always finds room in the queue.
    assign w_credit_used = {1'b0, w_q_count} + {1'b0, w_inflight};

    // Requests still owed a response after a redirect edge: everything in
    // flight, plus this cycle's acceptance, minus this cycle's response.
    assign w_drop_redirect = w_inflight + CW'(w_req_fire) - CW'(imem_rsp_valid);

    if_sync_fifo #(
        .WIDTH (QW),
        .DEPTH (DEPTH)
    ) u_inst_q (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (redirect_valid),
        .i_push      (w_rsp_keep),
        .i_push_data ({imem_rsp_data, w_tag_head}),
        .i_pop       (w_inst_pop),
        .o_head      (w_q_head),
        .o_full      (w_q_full),
        .o_empty     (w_q_empty),
        .o_count     (w_q_count)
    );

    // PC of each outstanding request; its occupancy is the in-flight count.
    // Cleared on redirect because every outstanding response is then dropped.
    if_sync_fifo #(
        .WIDTH (XLEN),
        .DEPTH (DEPTH)
    ) u_tag_q (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (redirect_valid),
        .i_push      (w_req_fire),
        .i_push_data (r_fetch_pc),
        .i_pop       (w_rsp_keep),
        .o_head      (w_tag_head),
        .o_full      (w_tag_full),
        .o_empty     (w_tag_empty),
        .o_count     (w_inflight)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE: begin
                w_state_next = FETCH;
            end
            FETCH: begin
                if (redirect_valid && (w_drop_redirect != '0)) begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (r_drop_cnt == '0) begin
                    w_state_next = FETCH;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // FSM outputs
    always_comb begin
        imem_req_valid = 1'b0;
        if (r_state == FETCH) begin
            imem_req_valid = (w_credit_used < (CW + 1)'(DEPTH)) & ~w_q_full & ~w_tag_full;
        end
        imem_req_addr = r_fetch_pc;
        inst_valid    = ~w_q_empty;
        inst_data     = NOP_INSTR;
        inst_pc       = RESET_PC;
        if (!w_q_empty) begin
            {inst_data, inst_pc} = w_q_head;
        end
    end

    // Fetch PC and drop counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_fetch_pc <= RESET_PC;
            r_drop_cnt <= '0;
        end else begin
            if (redirect_valid) begin
                r_fetch_pc <= redirect_pc & ~XLEN'(3);
            end else if (w_req_fire) begin
                r_fetch_pc <= r_fetch_pc + XLEN'(PC_STEP);
            end

            if ((r_state == FETCH) && redirect_valid) begin
                r_drop_cnt <= w_drop_redirect;
            end else if ((r_state == DRAIN) && imem_rsp_valid && (r_drop_cnt != '0)) begin
                r_drop_cnt <= r_drop_cnt - 1'b1;
            end
        end
    end

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (inst_ready && !inst_valid && (stall_cycles != 32'hFFFF_FFFF)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (redirect_valid && (flush_count != 32'hFFFF_FFFF)) begin
                flush_count <= flush_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_prefetch_unit.sv
// -----------------------------------------------------------------------------
// tb_if_prefetch_unit
// Directed and randomized stimulus for if_prefetch_unit. A behavioural memory
// (in-order, configurable latency) answers requests with a word derived from
// the address; a scoreboard expects decode to see consecutive PCs starting at
// the reset PC or the last redirect target, and requests to walk the same
// stream. Build with IF_PERF_CNT_EN to also check the performance counters.
// -----------------------------------------------------------------------------
module tb_if_prefetch_unit;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
`ifdef IF_PERF_CNT_EN
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;
`endif

    if_prefetch_unit #(
        .XLEN     (XLEN),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc)
`ifdef IF_PERF_CNT_EN
        ,
        .stall_cycles   (stall_cycles),
        .flush_count    (flush_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, observed still running, required finish");
        $fatal(1, "time limit reached");
    end

    // Counters and stimulus state
    int          n_assert = 0;
    int          n_fail   = 0;
    int unsigned cyc      = 0;
    int unsigned lat      = 1;
    int unsigned n_reqs   = 0;
    int unsigned n_pops   = 0;
    logic        s_rst, s_ready, s_inst_ready, s_redir;
    logic [31:0] s_redir_pc;

    // Reference model state
    logic [31:0] exp_pc;
    logic [31:0] exp_req;
    logic [31:0] pend_addr[$];
    int unsigned pend_due[$];
    int unsigned m_stall = 0;
    int unsigned m_flush = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0003;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: apply stimulus and memory response after the rising edge,
    // then observe this cycle's handshakes on the falling edge.
    task automatic cycle();
        @(posedge clk);
        cyc++;
        #1;
        rst            = s_rst;
        imem_req_ready = s_ready;
        inst_ready     = s_inst_ready;
        redirect_valid = s_redir;
        redirect_pc    = s_redir_pc;
        if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend_addr[0]);
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom();
        end
        @(negedge clk);
        if (rst) begin
            if (imem_req_valid && imem_req_ready) begin
                check("req_addr", imem_req_addr, exp_req);
                pend_addr.push_back(imem_req_addr);
                pend_due.push_back(cyc + lat);
                exp_req = exp_req + 32'd4;
                n_reqs++;
            end
            if (inst_valid && inst_ready) begin
                check("inst_pc", inst_pc, exp_pc);
                check("inst_data", inst_data, mem_word(exp_pc));
                exp_pc = exp_pc + 32'd4;
                n_pops++;
            end
            if (inst_ready && !inst_valid) m_stall++;
            if (redirect_valid) begin
                m_flush++;
                exp_pc  = redirect_pc & ~32'd3;
                exp_req = redirect_pc & ~32'd3;
            end
        end else begin
            pend_addr.delete();
            pend_due.delete();
            exp_pc  = RESET_PC;
            exp_req = RESET_PC;
            m_stall = 0;
            m_flush = 0;
        end
    endtask

    initial begin
        int unsigned p0;
        int unsigned r0;
        int unsigned quiet;
        logic        found;

        rst = 1'b0; imem_req_ready = 1'b1; inst_ready = 1'b1;
        redirect_valid = 1'b0; redirect_pc = '0;
        imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        s_rst = 1'b0; s_ready = 1'b1; s_inst_ready = 1'b1; s_redir = 1'b0; s_redir_pc = '0;
        exp_pc = RESET_PC; exp_req = RESET_PC;

        // Reset values
        cycle(); cycle();
        check("rst_req_valid", imem_req_valid, 0);
        check("rst_req_addr", imem_req_addr, RESET_PC);
        check("rst_inst_valid", inst_valid, 0);
        check("rst_inst_data", inst_data, NOP);
        check("rst_inst_pc", inst_pc, RESET_PC);

        // 1-cycle memory, streaming
        s_rst = 1'b1;
        cycle();
        check("idle_no_req", imem_req_valid, 0);
        cycle();
        check("first_req_valid", imem_req_valid, 1);
        check("first_req_addr", imem_req_addr, RESET_PC);
        cycle();
        check("rsp_cycle_inst_valid", inst_valid, 0);
        cycle();
        check("first_inst_valid", inst_valid, 1);
        check("first_inst_pc", inst_pc, RESET_PC);
        p0 = n_pops;
        repeat (20) cycle();
        check("throughput_20", n_pops - p0, 20);

        // Backpressure: credit limits outstanding work to DEPTH
        s_rst = 1'b0; s_inst_ready = 1'b0;
        cycle();
        s_rst = 1'b1;
        r0 = n_reqs;
        repeat (12) cycle();
        check("bp_req_count", n_reqs - r0, DEPTH);
        check("bp_req_valid", imem_req_valid, 0);
        check("bp_inst_valid", inst_valid, 1);
        check("bp_head_pc", inst_pc, 32'h0);
        s_inst_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            cycle();
            if (imem_req_valid) found = 1'b1;
        end
        check("bp_resume_seen", found, 1);
        check("bp_resume_addr", imem_req_addr, 32'h10);
        repeat (10) cycle();

        // 3-cycle memory, redirect with two requests in flight
        s_rst = 1'b0; lat = 3;
        cycle();
        s_rst = 1'b1;
        cycle();
        r0 = n_reqs;
        cycle(); cycle();
        check("drain_two_inflight", n_reqs - r0, 2);
        s_ready = 1'b0; s_redir = 1'b1; s_redir_pc = 32'h100;
        cycle();
        s_redir = 1'b0; s_ready = 1'b1;
        quiet = 0; found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            cycle();
            if (imem_req_valid) found = 1'b1;
            else quiet++;
        end
        check("drain_quiet", quiet >= 2, 1);
        check("drain_restart_addr", imem_req_addr, 32'h100);
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            cycle();
            if (inst_valid) found = 1'b1;
        end
        check("drain_first_valid", found, 1);
        check("drain_first_pc", inst_pc, 32'h100);
        repeat (8) cycle();

        // Redirect with nothing in flight, unaligned target
        s_rst = 1'b0; lat = 1; s_ready = 1'b0;
        cycle();
        s_rst = 1'b1;
        cycle(); cycle();
        check("nodrain_pending", imem_req_valid, 1);
        s_redir = 1'b1; s_redir_pc = 32'h203;
        cycle();
        s_redir = 1'b0;
        cycle();
        check("nodrain_req_valid", imem_req_valid, 1);
        check("nodrain_aligned_addr", imem_req_addr, 32'h200);
        s_ready = 1'b1;
        repeat (6) cycle();

        // PC wrap across 2^32
        s_redir = 1'b1; s_redir_pc = 32'hFFFF_FFFA;
        cycle();
        s_redir = 1'b0;
        p0 = n_pops;
        repeat (15) cycle();
        check("wrap_progress", n_pops - p0 >= 4, 1);

        // Reset mid-stream
        s_rst = 1'b0;
        cycle();
        s_rst = 1'b1;
        cycle();
        check("midrst_inst_valid", inst_valid, 0);
        check("midrst_req_addr", imem_req_addr, RESET_PC);
        check("midrst_idle", imem_req_valid, 0);
        cycle();
        check("midrst_restart_valid", imem_req_valid, 1);
        check("midrst_restart_addr", imem_req_addr, RESET_PC);
        repeat (6) cycle();

`ifdef IF_PERF_CNT_EN
        // 5 stall cycles then 2 redirects
        s_rst = 1'b0; s_ready = 1'b0; s_inst_ready = 1'b1;
        cycle();
        s_rst = 1'b1;
        repeat (5) cycle();
        s_inst_ready = 1'b0; s_redir = 1'b1; s_redir_pc = 32'h40;
        repeat (2) cycle();
        s_redir = 1'b0;
        cycle();
        check("perf_stall_5", stall_cycles, 5);
        check("perf_flush_2", flush_count, 2);
        s_ready = 1'b1; s_inst_ready = 1'b1;
`endif

        // Randomized traffic
        s_rst = 1'b0;
        cycle();
        s_rst = 1'b1;
        p0 = n_pops;
        for (int i = 0; i < 1500; i++) begin
            s_ready      = ($urandom_range(0, 3) != 0);
            s_inst_ready = ($urandom_range(0, 3) != 0);
            s_redir      = ($urandom_range(0, 39) == 0);
            s_redir_pc   = $urandom();
            if ($urandom_range(0, 99) == 0) lat = $urandom_range(1, 4);
            cycle();
        end
        check("rand_progress", n_pops - p0 > 200, 1);
        s_redir = 1'b0; s_inst_ready = 1'b0;
        cycle();
`ifdef IF_PERF_CNT_EN
        check("rand_perf_stall", stall_cycles, m_stall);
        check("rand_perf_flush", flush_count, m_flush);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
